// File: rtl/eth_tx_arb.sv
// Round-robin start scheduler for two Manchester transmitters sharing one 10BASE-T TX pin.
// Optional link-pulse generation (idle counter + NLP state) is enabled by defining ETH_ARB_NLP_EN.
module eth_tx_arb #(
  parameter int FRAME_CYCLES = 1400,
  parameter int IFG_CYCLES   = 192,
  parameter int NLP_PERIOD   = 320000,
  parameter int NLP_WIDTH    = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] ack,
  output logic [1:0] start,
  input  logic [1:0] tx_in,
  output logic       tx_out,
  output logic       owner,
  output logic       busy
);

  localparam int MAX_FG = (FRAME_CYCLES > IFG_CYCLES) ? FRAME_CYCLES : IFG_CYCLES;
  localparam int MAX_NL = (NLP_PERIOD > NLP_WIDTH) ? NLP_PERIOD : NLP_WIDTH;
  localparam int MAX_P  = (MAX_FG > MAX_NL) ? MAX_FG : MAX_NL;
  localparam int CNT_W  = $clog2(MAX_P) + 1;

  localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_CYCLES - 1);
  localparam logic [CNT_W-1:0] IFG_LAST   = CNT_W'(IFG_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FRAME = 2'd1,
    GAP   = 2'd2,
    NLP   = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [1:0]       start_nxt, ack_nxt;
  logic             owner_nxt, busy_nxt, tx_nxt;
  logic             grant, gnt_idx;
  logic             nlp_due;

  // Single request wins outright; contention goes to the client that did not own the line last.
  function automatic logic rr_pick(input logic [1:0] r, input logic last);
    if (r == 2'b11) return ~last;
    return r[1];
  endfunction

`ifdef ETH_ARB_NLP_EN
  localparam logic [CNT_W-1:0] NLP_LAST   = CNT_W'(NLP_PERIOD - 1);
  localparam logic [CNT_W-1:0] NLP_W_LAST = CNT_W'(NLP_WIDTH - 1);

  logic [CNT_W-1:0] idle_cnt, idle_cnt_nxt;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic [CNT_W-1:0] lim);
    if (v == lim) return v;
    return v + 1'b1;
  endfunction

  assign nlp_due = (idle_cnt == NLP_LAST);

  always_comb begin
    idle_cnt_nxt = idle_cnt;
    if (grant)
      idle_cnt_nxt = '0;
    else if (state == NLP && cnt == NLP_W_LAST)
      idle_cnt_nxt = '0;
    else if (state == IDLE || state == GAP)
      idle_cnt_nxt = sat_inc(idle_cnt, NLP_LAST);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) idle_cnt <= '0;
    else        idle_cnt <= idle_cnt_nxt;
  end
`else
  assign nlp_due = 1'b0;
`endif

  assign grant   = (state == IDLE) && (req != 2'b00);
  assign gnt_idx = rr_pick(req, owner);

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      start  <= 2'b00;
      ack    <= 2'b00;
      tx_out <= 1'b0;
      busy   <= 1'b0;
      owner  <= 1'b1;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      start  <= start_nxt;
      ack    <= ack_nxt;
      tx_out <= tx_nxt;
      busy   <= busy_nxt;
      owner  <= owner_nxt;
    end
  end

  // Next state: a pending request always beats a due link pulse
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        if (req != 2'b00) begin
          state_nxt = FRAME;
          cnt_nxt   = '0;
        end else if (nlp_due) begin
          state_nxt = NLP;
          cnt_nxt   = '0;
        end
      end
      FRAME: begin
        if (cnt == FRAME_LAST) begin
          state_nxt = GAP;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      GAP: begin
        if (cnt == IFG_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`ifdef ETH_ARB_NLP_EN
      NLP: begin
        if (cnt == NLP_W_LAST) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
`endif
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // Output values to be registered at the next edge
  always_comb begin
    start_nxt = 2'b00;
    ack_nxt   = 2'b00;
    owner_nxt = owner;
    if (grant) begin
      start_nxt = gnt_idx ? 2'b10 : 2'b01;
      ack_nxt   = gnt_idx ? 2'b10 : 2'b01;
      owner_nxt = gnt_idx;
    end
    busy_nxt = (state_nxt != IDLE);
    tx_nxt   = 1'b0;
    if (state == FRAME)
      tx_nxt = tx_in[owner];
    else if (state == NLP)
      tx_nxt = 1'b1;
  end

endmodule

// File: tb/tb_eth_tx_arb.sv
// Directed bench for eth_tx_arb with FRAME_CYCLES=20, IFG_CYCLES=8, NLP_PERIOD=100, NLP_WIDTH=2.
// Link-pulse checks follow ETH_ARB_NLP_EN; otherwise the line must stay quiet when idle.
module tb_eth_tx_arb;
  localparam int FC  = 20;
  localparam int IFG = 8;
  localparam int NP  = 100;
  localparam int NW  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req, ack, start, tx_in;
  logic       tx_out, owner, busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  eth_tx_arb #(
    .FRAME_CYCLES(FC),
    .IFG_CYCLES  (IFG),
    .NLP_PERIOD  (NP),
    .NLP_WIDTH   (NW)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .ack   (ack),
    .start (start),
    .tx_in (tx_in),
    .tx_out(tx_out),
    .owner (owner),
    .busy  (busy)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // The 28 edges after a start: no further start/ack, busy high through the last GAP cycle.
  task automatic frame_gap();
    for (int i = 1; i <= FC + IFG; i++) begin
      step();
      chk("quiet_start", start, 2'b00);
      chk("quiet_ack", ack, 2'b00);
      chk("busy_window", busy, (i <= FC + IFG - 1));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 2'b11;
    tx_in = 2'b11;

    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_start", start, 2'b00);
      chk("rst_ack", ack, 2'b00);
      chk("rst_tx", tx_out, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_owner", owner, 1'b1);
    end

    // Contention: held 2'b11 alternates grants 29 cycles apart, client 0 first
    rst_n = 1'b1;
    step();
    chk("first_start", start, 2'b01);
    chk("first_ack", ack, 2'b01);
    chk("first_owner", owner, 1'b0);
    chk("first_busy", busy, 1'b1);
    for (int k = 1; k <= 3; k++) begin
      frame_gap();
      step();
      chk("rr_start", start, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("rr_ack", ack, (k % 2 == 1) ? 2'b10 : 2'b01);
      chk("rr_owner", owner, (k % 2 == 1) ? 1'b1 : 1'b0);
    end

    // Single client with request held
    rst_n = 1'b0;
    req   = 2'b00;
    step();
    rst_n = 1'b1;
    req   = 2'b01;
    step();
    chk("single_start", start, 2'b01);
    chk("single_ack", ack, 2'b01);
    chk("single_busy", busy, 1'b1);
    frame_gap();
    step();
    chk("single_next", start, 2'b01);
    req = 2'b00;
    frame_gap();

    // Mux: client 1 owns the line, client 0 drives a constant 1
    req = 2'b10;
    step();
    chk("mux_start", start, 2'b10);
    chk("mux_owner", owner, 1'b1);
    req = 2'b00;
    for (int i = 0; i < FC; i++) begin
      logic b;
      b = (i % 2 == 0);
      tx_in = {b, 1'b1};
      step();
      chk("mux_tx", tx_out, b);
    end
    tx_in = 2'b11;
    for (int i = 0; i < IFG; i++) begin
      step();
      chk("gap_tx", tx_out, 1'b0);
    end
    chk("mux_idle", busy, 1'b0);

    // Mid-frame reset at cnt=10, client 0 driving 1
    req = 2'b01;
    step();
    chk("mf_start", start, 2'b01);
    for (int i = 0; i < 10; i++) step();
    chk("mf_tx_before", tx_out, 1'b1);
    rst_n = 1'b0;
    step();
    chk("mf_busy", busy, 1'b0);
    chk("mf_tx", tx_out, 1'b0);
    chk("mf_start0", start, 2'b00);
    chk("mf_owner", owner, 1'b1);
    rst_n = 1'b1;
    step();
    chk("mf_regrant", start, 2'b01);
    chk("mf_reack", ack, 2'b01);
    req = 2'b00;

    // Idle line behaviour from a fresh reset
    rst_n = 1'b0;
    tx_in = 2'b00;
    step();
    rst_n = 1'b1;
`ifdef ETH_ARB_NLP_EN
    for (int c = 1; c <= 305; c++) begin
      step();
      chk("nlp_tx", tx_out, (c == 101 || c == 102 || c == 203 || c == 204 || c == 305));
      chk("nlp_busy", busy, (c == 100 || c == 101 || c == 202 || c == 203 || c == 304 || c == 305));
    end
    req = 2'b01;
    step();
    chk("nlp_req_tx", tx_out, 1'b1);
    chk("nlp_req_wait", start, 2'b00);
    step();
    chk("nlp_req_start", start, 2'b01);
    chk("nlp_req_tx0", tx_out, 1'b0);
    req = 2'b00;
`else
    begin
      int hi_tx;
      int hi_busy;
      hi_tx   = 0;
      hi_busy = 0;
      for (int c = 1; c <= 1000; c++) begin
        step();
        if (tx_out !== 1'b0) hi_tx++;
        if (busy !== 1'b0) hi_busy++;
      end
      chk("nonlp_tx", hi_tx, 0);
      chk("nonlp_busy", hi_busy, 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/eth_tx_arb.md
Name: eth_tx_arb

Overview:
- Scheduler and arbiter placed in front of two Manchester frame transmitters that share one 10BASE-T TX pin.
- Accepts frame requests from two clients and issues one-cycle start pulses round-robin, so that only one transmitter runs at a time.
- Enforces frame duration and inter-frame gap, and muxes the owning transmitter's line onto a registered TX output.
- Emits normal link pulses (NLP) when the line is idle.
- Runs in the clk_eth domain (20 MHz nominal).

Parameters:
- FRAME_CYCLES, 1400: cycles a granted frame owns the line, counted from the start pulse; must cover transmitter latency plus full frame.
- IFG_CYCLES, 192: forced-idle cycles after each frame (9.6 us at 20 MHz).
- NLP_PERIOD, 320000: idle cycles before an NLP is emitted (16 ms).
- NLP_WIDTH, 2: NLP high time in cycles (100 ns).
- Constraints: all parameters >= 1; NLP_PERIOD > IFG_CYCLES.
- Counter widths: $clog2 of the largest parameter, plus 1.

Ports:
- clk  in  1  clock (clk_eth domain)
- rst_n  in  1  synchronous reset, active-low
- req  in  2  level frame request per client; held until ack
- ack  out  2  one-cycle pulse, same cycle as the matching start bit
- start  out  2  one-cycle start pulse to transmitter i
- tx_in  in  2  serial line from transmitter i
- tx_out  out  1  registered line to the pin
- owner  out  1  index of the last/current granted client
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: rst_n low at a clk edge forces the following values at that edge, regardless of state, including mid-frame or mid-NLP:
  - state=IDLE, start=0, ack=0, tx_out=0, busy=0, owner=1 (so client 0 wins first), all counters 0.
- States: IDLE, FRAME, GAP, NLP. All outputs are registered.
- IDLE:
  - If req != 0, grant g:
    - only one bit set -> that client;
    - both bits set -> g = ~owner.
  - Next cycle: state=FRAME, start[g]=1, ack[g]=1, owner=g, cnt=0.
  - start and ack are high for exactly that one cycle.
- FRAME:
  - Lasts FRAME_CYCLES cycles, including the start cycle; cnt increments each cycle.
  - When cnt==FRAME_CYCLES-1 -> GAP, cnt=0.
  - New req are ignored.
- GAP:
  - Lasts IFG_CYCLES cycles, then IDLE.
- Earliest next start for a request held throughout: FRAME_CYCLES+IFG_CYCLES+1 cycles after the previous start.
- tx_out, registered with one-cycle latency:
  - tx_out(t+1) = tx_in[owner](t) while state(t)==FRAME;
  - = 1 while state(t)==NLP;
  - = 0 otherwise.
  - tx_in of the non-owner never reaches tx_out.
- Idle counter (feature only):
  - Cleared when a frame is granted and when NLP exits.
  - Increments in GAP and IDLE, saturating at NLP_PERIOD-1.
- NLP entry: in IDLE with idle_cnt==NLP_PERIOD-1 and req==0 -> NLP for NLP_WIDTH cycles, then IDLE.
- Simultaneous req and NLP due in IDLE: frame wins, and idle_cnt is cleared.
- req asserted during NLP waits until NLP completes; it is granted on the first IDLE cycle.
- req dropped before ack: no grant; no partial state change.

Optional Feature:
- Macro: ETH_ARB_NLP_EN.
- Defined: idle counter and NLP state present; behaviour as above.
- Undefined: idle counter and NLP state are not synthesised; tx_out stays 0 whenever no frame is active; NLP_* parameters are ignored.

Test Plan (FRAME_CYCLES=20, IFG_CYCLES=8, NLP_PERIOD=100, NLP_WIDTH=2 unless stated):
- Reset: rst_n=0 for 3 cycles with req=2'b11 and tx_in=2'b11 -> start=0, ack=0, tx_out=0, busy=0, owner=1 throughout; first grant after release is client 0.
- Single client: req=2'b01 is sampled at cycle T.
  - Required: start=2'b01 and ack=2'b01 at T+1 only.
  - busy high for cycles T+1..T+28.
  - With req held, next start[0] at T+30.
- Contention: req=2'b11 held -> starts alternate 01,10,01,10, spaced 29 cycles apart; owner tracks each grant.
- Mux: grant client 1, drive tx_in[1]=1010... and tx_in[0]=1 constant during FRAME -> tx_out equals tx_in[1] delayed by one cycle; tx_out=0 during GAP.
- NLP (macro defined), no requests after reset:
  - tx_out high for exactly 2 cycles, first pulse starting at cycle 101.
  - Pulse starts repeat every 102 cycles.
  - req raised during a pulse -> start issued on the cycle after the pulse ends.
  - With the macro undefined, tx_out stays 0 for 1000 cycles.
- Mid-frame reset: rst_n=0 for one cycle at FRAME cnt=10 -> next cycle IDLE, tx_out=0, busy=0; held req0 is re-granted one cycle after rst_n returns high.
